// File: rtl/missile_slot_arbiter.sv
// Shares a pool of missile slots between the player and the enemy shooters.
// Arbitrates once per frame, pulses the chosen slot, confirms launch, then applies cooldowns.
module missile_slot_arbiter #(
    parameter int SLOT_AMOUNT     = 8,
    parameter int ENEMY_AMOUNT    = 8,
    parameter int CD_WIDTH        = 6,
    parameter int PLAYER_COOLDOWN = 15,
    parameter int ENEMY_COOLDOWN  = 40,
    parameter int PLAYER_RESERVED = 2,
    parameter int CONFIRM_TIMEOUT = 4,
    localparam int IDX_W  = $clog2(ENEMY_AMOUNT),
    localparam int SLOT_W = $clog2(SLOT_AMOUNT)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    player_req,
    input  logic [ENEMY_AMOUNT-1:0] enemy_req,
    input  logic [SLOT_AMOUNT-1:0]  slot_active,
    output logic [SLOT_AMOUNT-1:0]  fire_slot,
    output logic                    fire_is_enemy,
    output logic [IDX_W-1:0]        fire_enemy_idx,
    output logic                    player_ready,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W  = $clog2(SLOT_AMOUNT + 1);
    localparam int CONF_W = $clog2(CONFIRM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_FIRE    = 2'd2,
        S_CONFIRM = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [SLOT_W-1:0]   r_sel_slot;
    logic                r_sel_enemy;
    logic [IDX_W-1:0]    r_sel_idx;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [CD_WIDTH-1:0] r_player_cd;
    logic [CD_WIDTH-1:0] r_enemy_cd;
    logic [CONF_W-1:0]   r_conf_cnt;

    logic [SLOT_AMOUNT-1:0] w_free;
    logic [CNT_W-1:0]       w_free_cnt;
    logic [SLOT_W-1:0]      w_low_slot;
    logic                   w_rr_found;
    logic [IDX_W-1:0]       w_rr_idx;
    logic                   w_player_grant;
    logic                   w_enemy_grant;
    logic                   w_latch;
    logic                   w_confirm;

    // Free-slot census, lowest free slot and round-robin enemy pick.
    always_comb begin
        int j;
        j          = 0;
        w_free     = ~slot_active;
        w_free_cnt = '0;
        w_low_slot = '0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int i = 0; i < SLOT_AMOUNT; i++) begin
            w_free_cnt = w_free_cnt + CNT_W'(w_free[i]);
        end
        for (int i = SLOT_AMOUNT - 1; i >= 0; i--) begin
            if (w_free[i]) w_low_slot = SLOT_W'(i);
        end
        // Explicit wrap keeps non-power-of-two enemy counts correct.
        for (int k = 0; k < ENEMY_AMOUNT; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= ENEMY_AMOUNT) j = j - ENEMY_AMOUNT;
            if (!w_rr_found && enemy_req[IDX_W'(j)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'(j);
            end
        end
        w_player_grant = player_req && (r_player_cd == '0) && (w_free_cnt != '0);
        w_enemy_grant  = !w_player_grant && (r_enemy_cd == '0) &&
                         (w_free_cnt > CNT_W'(PLAYER_RESERVED)) && w_rr_found;
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_confirm    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (startOfFrame) w_next_state = S_ARB;
            end
            S_ARB: begin
                if (w_player_grant || w_enemy_grant) begin
                    w_next_state = S_FIRE;
                    w_latch      = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FIRE: begin
                w_next_state = S_CONFIRM;
            end
            S_CONFIRM: begin
                if (slot_active[r_sel_slot]) begin
                    w_confirm    = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_conf_cnt == CONF_W'(CONFIRM_TIMEOUT - 1)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_sel_slot  <= '0;
            r_sel_enemy <= 1'b0;
            r_sel_idx   <= '0;
            r_rr_ptr    <= '0;
            r_player_cd <= '0;
            r_enemy_cd  <= '0;
            r_conf_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_sel_slot  <= w_low_slot;
                r_sel_enemy <= !w_player_grant;
                r_sel_idx   <= w_player_grant ? '0 : w_rr_idx;
            end
            r_conf_cnt <= (r_state == S_CONFIRM) ? r_conf_cnt + CONF_W'(1) : '0;
            // A cooldown load takes precedence over the frame decrement.
            if (w_confirm && !r_sel_enemy) begin
                r_player_cd <= CD_WIDTH'(PLAYER_COOLDOWN);
            end else if (startOfFrame && r_player_cd != '0) begin
                r_player_cd <= r_player_cd - CD_WIDTH'(1);
            end
            if (w_confirm && r_sel_enemy) begin
                r_enemy_cd <= CD_WIDTH'(ENEMY_COOLDOWN);
                r_rr_ptr   <= (r_sel_idx == IDX_W'(ENEMY_AMOUNT - 1)) ? '0 : r_sel_idx + IDX_W'(1);
            end else if (startOfFrame && r_enemy_cd != '0) begin
                r_enemy_cd <= r_enemy_cd - CD_WIDTH'(1);
            end
        end
    end

    assign fire_slot      = (r_state == S_FIRE) ? (SLOT_AMOUNT'(1) << r_sel_slot) : '0;
    assign fire_is_enemy  = (r_state == S_FIRE) && r_sel_enemy;
    assign fire_enemy_idx = (r_state == S_FIRE) ? r_sel_idx : '0;
    assign player_ready   = (r_player_cd == '0);
    assign busy           = (r_state != S_IDLE);
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_missile_slot_arbiter.sv
// Bench for missile_slot_arbiter: directed scenarios plus random traffic, all outputs
// compared every cycle against a frame/timeline model of the arbitration rules.
module tb_missile_slot_arbiter;

    localparam int SA  = 8;
    localparam int EA  = 8;
    localparam int PCD = 15;
    localparam int ECD = 40;
    localparam int RES = 2;
    localparam int TO  = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0;
    logic       player_req = 1'b0;
    logic [7:0] enemy_req = '0;
    logic [7:0] slot_active;
    logic [7:0] fire_slot;
    logic       fire_is_enemy;
    logic [2:0] fire_enemy_idx;
    logic       player_ready;
    logic       busy;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    missile_slot_arbiter dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof),
        .player_req     (player_req),
        .enemy_req      (enemy_req),
        .slot_active    (slot_active),
        .fire_slot      (fire_slot),
        .fire_is_enemy  (fire_is_enemy),
        .fire_enemy_idx (fire_enemy_idx),
        .player_ready   (player_ready),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- missile slot array emulation ----------------
    logic [7:0] emu_active = '0;
    logic [7:0] force_mask = '0;
    int  life[SA] = '{default: 0};
    int  pend[SA] = '{default: -1};
    int  life_lo = 60, life_hi = 60, act_hi = 0, never_pct = 0, bg_pm = 0;
    bit  no_confirm = 1'b0;

    assign slot_active = emu_active | force_mask;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < SA; i++) begin
            if (fire_slot[i] && !no_confirm && $urandom_range(0, 99) >= never_pct)
                pend[i] = $urandom_range(0, act_hi);
            if (life[i] > 0) life[i]--;
            if (pend[i] == 0) begin
                life[i] = $urandom_range(life_lo, life_hi);
                pend[i] = -1;
            end else if (pend[i] > 0) begin
                pend[i]--;
            end else if (life[i] == 0 && bg_pm > 0 && $urandom_range(0, 999) < bg_pm) begin
                life[i] = $urandom_range(life_lo, life_hi);
            end
            emu_active[i] = (life[i] > 0);
        end
    end

    // ---------------- reference model (timeline of frame events) ----------------
    int   cyc = 0, m_pcd = 0, m_ecd = 0, m_rr = 0, m_sel = 0, m_idx = 0;
    int   m_arb_edge = -1, m_fire_edge = -100;
    bit   m_active = 1'b0, m_side = 1'b0, m_fire_now = 1'b0;
    logic [7:0] e_fire = '0;
    logic       e_is_enemy = 1'b0;
    logic [2:0] e_idx = '0;
    logic       e_busy = 1'b0, e_ready = 1'b1;

    always @(posedge clk or negedge resetN) begin
        int p0, e0, nfree, pick;
        bit ld_p, ld_e;
        logic [7:0] fr;
        if (!resetN) begin
            m_pcd = 0; m_ecd = 0; m_rr = 0; m_active = 1'b0; m_fire_now = 1'b0;
            e_fire = '0; e_is_enemy = 1'b0; e_idx = '0; e_busy = 1'b0; e_ready = 1'b1;
        end else begin
            cyc++;
            p0 = m_pcd; e0 = m_ecd; ld_p = 1'b0; ld_e = 1'b0; m_fire_now = 1'b0;
            if (!m_active) begin
                if (sof) begin
                    m_active   = 1'b1;
                    m_arb_edge = cyc + 1;
                end
            end else if (cyc == m_arb_edge) begin
                fr = ~slot_active;
                nfree = $countones(fr);
                pick = -1;
                if (player_req && p0 == 0 && nfree >= 1) begin
                    m_side = 1'b0;
                    pick = 0;
                end else if (e0 == 0 && nfree > RES && enemy_req != 0) begin
                    m_side = 1'b1;
                    for (int k = EA - 1; k >= 0; k--)
                        if (enemy_req[(m_rr + k) % EA]) pick = (m_rr + k) % EA;
                end
                if (pick >= 0) begin
                    m_idx = pick;
                    for (int i = SA - 1; i >= 0; i--) if (fr[i]) m_sel = i;
                    m_fire_edge = cyc;
                    m_fire_now = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end else if (cyc >= m_fire_edge + 2) begin
                if (slot_active[m_sel]) begin
                    if (m_side) begin
                        ld_e = 1'b1;
                        m_rr = (m_idx + 1) % EA;
                    end else begin
                        ld_p = 1'b1;
                    end
                    m_active = 1'b0;
                end else if (cyc == m_fire_edge + 1 + TO) begin
                    m_active = 1'b0;
                end
            end
            m_pcd = ld_p ? PCD : ((sof && p0 > 0) ? p0 - 1 : p0);
            m_ecd = ld_e ? ECD : ((sof && e0 > 0) ? e0 - 1 : e0);
            e_fire     = m_fire_now ? (8'(1) << m_sel) : 8'h00;
            e_is_enemy = m_fire_now && m_side;
            e_idx      = 3'(m_idx);
            e_busy     = m_active;
            e_ready    = (m_pcd == 0);
        end
    end

    always @(negedge clk) begin
        check("cyc_fire_slot", fire_slot, e_fire);
        check("cyc_fire_is_enemy", fire_is_enemy, e_is_enemy);
        if (e_is_enemy) check("cyc_fire_enemy_idx", fire_enemy_idx, e_idx);
        check("cyc_busy", busy, e_busy);
        check("cyc_player_ready", player_ready, e_ready);
    end

    // ---------------- driver tasks ----------------
    task automatic sof_pulse();
        @(posedge clk); #2 sof = 1'b1;
        @(posedge clk); #2 sof = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            sof_pulse();
            repeat (6) @(posedge clk);
        end
    endtask

    task automatic wait_fire(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (fire_slot != 0) got = 1'b1;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic expect_fire(input string name, input logic [7:0] slot, input bit is_e,
                               input logic [2:0] idx, output int idle_n);
        bit got;
        wait_fire(6, got);
        check({name, "_fired"}, got, 1'b1);
        if (got) begin
            check({name, "_slot"}, fire_slot, slot);
            check({name, "_is_enemy"}, fire_is_enemy, is_e);
            if (is_e) check({name, "_idx"}, fire_enemy_idx, idx);
        end
        wait_idle(idle_n);
    endtask

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        int  n;
        bit  got;
        repeat (3) @(posedge clk);
        #2 resetN = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_fire_slot", fire_slot, 8'h00);
        check("reset_player_ready", player_ready, 1'b1);

        // Player shot, fixed two-cycle latency, request dropped after arbitration.
        player_req = 1'b1;
        sof_pulse();
        @(negedge clk);
        check("t1_arb_no_pulse", fire_slot, 8'h00);
        @(posedge clk); #2 player_req = 1'b0;
        @(negedge clk);
        check("t1_slot", fire_slot, 8'h01);
        check("t1_is_enemy", fire_is_enemy, 1'b0);
        wait_idle(n);
        check("t1_ready_after_confirm", player_ready, 1'b0);
        frames(14);
        @(negedge clk);
        check("t1_ready_frame14", player_ready, 1'b0);
        frames(1);
        @(negedge clk);
        check("t1_ready_frame15", player_ready, 1'b1);

        // Round-robin: enemy 2 moves the pointer to 3, then 7 wins, then wraps to 2.
        enemy_req = 8'h04;
        sof_pulse();
        expect_fire("t2a", 8'h01, 1'b1, 3'd2, n);
        enemy_req = 8'h00;
        frames(40);
        enemy_req = 8'h84;
        sof_pulse();
        expect_fire("t2b", 8'h01, 1'b1, 3'd7, n);
        enemy_req = 8'h00;
        frames(40);
        enemy_req = 8'h84;
        sof_pulse();
        expect_fire("t2c", 8'h01, 1'b1, 3'd2, n);
        enemy_req = 8'h00;

        // Player priority over all enemies, enemy next frame.
        frames(40);
        player_req = 1'b1;
        enemy_req  = 8'hFF;
        sof_pulse();
        expect_fire("t3a", 8'h01, 1'b0, 3'd0, n);
        player_req = 1'b0;
        sof_pulse();
        expect_fire("t3b", 8'h02, 1'b1, 3'd3, n);
        enemy_req = 8'h00;

        // Reserved slots: two free slots are not enough for an enemy, enough for the player.
        force_mask = 8'hFC;
        enemy_req  = 8'h01;
        frames(40);
        sof_pulse();
        wait_fire(6, got);
        check("t4_enemy_blocked", got, 1'b0);
        wait_idle(n);
        player_req = 1'b1;
        sof_pulse();
        expect_fire("t4b", 8'h01, 1'b0, 3'd0, n);
        player_req = 1'b0;
        force_mask = 8'h00;
        enemy_req  = 8'h00;

        // Slot never reports active: timeout, no cooldown, fires again next frame.
        no_confirm = 1'b1;
        frames(15);
        player_req = 1'b1;
        sof_pulse();
        expect_fire("t5a", 8'h01, 1'b0, 3'd0, n);
        check("t5_timeout_len", n, 5);
        check("t5_ready_kept", player_ready, 1'b1);
        sof_pulse();
        expect_fire("t5b", 8'h01, 1'b0, 3'd0, n);
        player_req = 1'b0;

        // Reset during confirm clears everything, pointer back to enemy 0.
        no_confirm = 1'b0;
        player_req = 1'b1;
        sof_pulse();
        expect_fire("t6a", 8'h01, 1'b0, 3'd0, n);
        player_req = 1'b0;
        check("t6_ready_loaded", player_ready, 1'b0);
        no_confirm = 1'b1;
        enemy_req  = 8'h10;
        sof_pulse();
        wait_fire(6, got);
        check("t6b_fired", got, 1'b1);
        check("t6b_idx", fire_enemy_idx, 3'd4);
        @(posedge clk); #2 resetN = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_fire", fire_slot, 8'h00);
        check("t6_rst_ready", player_ready, 1'b1);
        @(posedge clk); #2 resetN = 1'b1;
        no_confirm = 1'b0;
        enemy_req  = 8'hFF;
        sof_pulse();
        expect_fire("t6c", 8'h02, 1'b1, 3'd0, n);
        enemy_req = 8'h00;

        // Random traffic with background missiles, late and missing confirmations.
        life_lo = 5; life_hi = 80; act_hi = 5; never_pct = 15; bg_pm = 30;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #2;
            sof = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) player_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) enemy_req = 8'($urandom_range(0, 255));
        end
        sof = 1'b0;
        player_req = 1'b0;
        enemy_req = 8'h00;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
